two_4_input_and_gate: RTL and testbench
=======================================

Name: two_4_input_and_gate

Overview:
Dual 4-input AND gate modelled on the 74LS21, for the 74LSxx component library. Two independent gates: Y1 = A1&B1&C1&D1 and Y2 = A2&B2&C2&D2. The output path is optionally registered through a configurable clocked delay line, so the block can stand in for a synchronous glue-logic gate in larger designs.

Parameters:
- Delay, default 1: number of clock-cycle register stages on each output. Legal range 0..16. 0 means a purely combinational output.

Ports:
- clk  input  1  system clock; rising edge active
- rst_n  input  1  reset; asynchronous, active-low
- A1, B1, C1, D1  input  1 each  gate 1 inputs
- A2, B2, C2, D2  input  1 each  gate 2 inputs
- Y1  output  1  gate 1 output
- Y2  output  1  gate 2 output

Behaviour:
- Logic: per gate, AND of its four inputs. Y is 1 only for input pattern 1111; all other 15 patterns give 0.
- The two gates are fully independent. Stimulus on gate 1 never affects Y2, and vice versa.
- Delay = 0:
  - Y1/Y2 are combinational and follow inputs in the same delta cycle.
  - clk and rst_n are ignored, and the block works with clk held constant.
- Delay = N >= 1:
  - Each gate has an N-stage shift register. Stage 0 samples the AND result at the rising clk edge.
  - Y equals the last stage, so an input change is visible exactly N rising edges later.
  - Inputs are sampled only at clk edges. Pulses shorter than a clock period between edges are not captured.
- Reset (Delay >= 1):
  - rst_n low asynchronously clears all stages, so Y1 = Y2 = 0 immediately, without waiting for clk.
  - Reset asserted mid-stream discards all in-flight values.
  - After rst_n deasserts, the first sample is taken on the next rising edge. Y stays 0 until N edges have passed, unless the inputs make the AND result 0 anyway.
- X/Z on any input propagates according to standard 4-state AND rules; the block performs no sanitising.
- A Delay value outside 0..16 is an elaboration-time error (fatal check in an initial/generate block).

Optional Feature:
- Macro AND_GATE_EDGE_CNT_EN.
- Defined:
  - Adds outputs Y1_rise_cnt and Y2_rise_cnt, 8 bits each.
  - Each counts 0->1 transitions of its registered Y, and saturates at 255 (no wrap).
  - Asynchronously cleared to 0 by rst_n.
  - With Delay = 0, the counter samples combinational Y at the rising clk edge, using a 1-stage edge-detect register.
- Not defined: the ports and logic are absent; the interface is exactly as listed under Ports.

Decomposition:
- Shared package and_gate_pkg:
  - DELAY_MAX = 16
  - EDGE_CNT_W = 8
  - typedef edge_cnt_t (logic [EDGE_CNT_W-1:0])
- Sub-module and4_delay_line: one 4-input AND plus the parameterised N-stage delay line and the optional edge counter. Instantiated twice, once per gate.
- The top level does only wiring and the parameter legality check.

Test Plan:
1. Delay=0, no clock. Hold gate 2 at 0000 and walk gate 1 through all 16 patterns, 2 ns apart -> Y1 = 1 only at 1111, Y2 = 0 throughout. Then hold gate 1 at 1111 and walk gate 2 -> Y2 = 1 only at 1111, Y1 stays 1.
2. Delay=1, 10 ns clock. Drive gate 1 from 1110 to 1111 just after an edge -> Y1 goes 0->1 at the next rising edge, not before. Return to 0111 -> Y1 = 0 one edge later.
3. Delay=3. Apply 1111 to both gates for one cycle, then 0000 -> Y1 and Y2 each show a single 1-cycle pulse, starting exactly 3 edges after the apply edge.
4. Delay=3, inputs 1111, pipeline full (Y = 1). Pull rst_n low between clock edges -> Y1 = Y2 = 0 immediately. Release rst_n -> Y stays 0 for 2 edges and returns to 1 on the 3rd edge.
5. Independence, Delay=2: toggle gate 2 inputs every cycle while gate 1 is held at 1111 -> Y1 stays 1 constantly, and Y2 tracks the gate 2 AND result with 2-cycle lag.
6. With AND_GATE_EDGE_CNT_EN, Delay=1: produce 300 separate 1-cycle 1111 pulses on gate 1 -> Y1_rise_cnt = 255 (saturated) and Y2_rise_cnt = 0. Then assert rst_n low -> both counters read 0.

Source files
------------

// File: rtl/and_gate_pkg.sv
// rtl/and_gate_pkg.sv - shared constants and types for the 74LS21-style dual AND gate
package and_gate_pkg;

  localparam int DELAY_MAX  = 16;
  localparam int EDGE_CNT_W = 8;

  typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;

  localparam edge_cnt_t EDGE_CNT_MAX = '1;

  // Saturating increment: the counter sticks at its maximum instead of wrapping.
  function automatic edge_cnt_t sat_inc(input edge_cnt_t c);
    return (c == EDGE_CNT_MAX) ? c : edge_cnt_t'(c + 1'b1);
  endfunction

endpackage

// File: rtl/and4_delay_line.sv
// rtl/and4_delay_line.sv - one 4-input AND with an N-stage output delay line
// Optional rising-edge counter on the output when AND_GATE_EDGE_CNT_EN is defined.
module and4_delay_line
  import and_gate_pkg::*;
#(
  parameter int DELAY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_a,
  input  logic      i_b,
  input  logic      i_c,
  input  logic      i_d,
  output logic      o_y
`ifdef AND_GATE_EDGE_CNT_EN
  ,
  output edge_cnt_t o_rise_cnt
`endif
);

  logic w_and;

  assign w_and = i_a & i_b & i_c & i_d;

  generate
    if (DELAY == 0) begin : g_comb
      // Purely combinational: clock and reset only matter to the optional counter.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;
      assign o_y = w_and;
    end else begin : g_pipe
      logic [DELAY-1:0] r_stage;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stage <= '0;
        end else begin
          r_stage[0] <= w_and;
          for (int i = 1; i < DELAY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_y = r_stage[DELAY-1];
    end
  endgenerate

`ifdef AND_GATE_EDGE_CNT_EN
  // The previous-output register doubles as the edge detector for the combinational case.
  logic      r_y_d;
  edge_cnt_t r_rise_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_d      <= 1'b0;
      r_rise_cnt <= '0;
    end else begin
      r_y_d <= o_y;
      if (o_y && !r_y_d) begin
        r_rise_cnt <= sat_inc(r_rise_cnt);
      end
    end
  end

  assign o_rise_cnt = r_rise_cnt;
`endif

endmodule

// File: rtl/two_4_input_and_gate.sv
// rtl/two_4_input_and_gate.sv - dual 4-input AND gate (74LS21) with configurable output delay
// Rise counters Y1_rise_cnt/Y2_rise_cnt exist only when AND_GATE_EDGE_CNT_EN is defined.
module two_4_input_and_gate
  import and_gate_pkg::*;
#(
  parameter int Delay = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      A1,
  input  logic      B1,
  input  logic      C1,
  input  logic      D1,
  input  logic      A2,
  input  logic      B2,
  input  logic      C2,
  input  logic      D2,
  output logic      Y1,
  output logic      Y2
`ifdef AND_GATE_EDGE_CNT_EN
  ,
  output edge_cnt_t Y1_rise_cnt,
  output edge_cnt_t Y2_rise_cnt
`endif
);

  generate
    if (Delay < 0 || Delay > DELAY_MAX) begin : g_bad_delay
      $fatal(1, "two_4_input_and_gate: Delay must be within 0..16");
    end
  endgenerate

  and4_delay_line #(
    .DELAY (Delay)
  ) u_gate1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_a        (A1),
    .i_b        (B1),
    .i_c        (C1),
    .i_d        (D1),
    .o_y        (Y1)
`ifdef AND_GATE_EDGE_CNT_EN
    ,
    .o_rise_cnt (Y1_rise_cnt)
`endif
  );

  and4_delay_line #(
    .DELAY (Delay)
  ) u_gate2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_a        (A2),
    .i_b        (B2),
    .i_c        (C2),
    .i_d        (D2),
    .o_y        (Y2)
`ifdef AND_GATE_EDGE_CNT_EN
    ,
    .o_rise_cnt (Y2_rise_cnt)
`endif
  );

endmodule

// File: tb/tb_two_4_input_and_gate.sv
// tb/tb_two_4_input_and_gate.sv - scoreboard bench for Delay 0/1/2/3 instances
// Counter checks are built only when AND_GATE_EDGE_CNT_EN is defined.
module tb_two_4_input_and_gate;

  typedef struct {
    time        t;
    int         dut;
    logic [7:0] e1;
    logic [7:0] e2;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic clk_hold = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] g1_d0 = 4'b0000, g2_d0 = 4'b0000;
  logic [3:0] g1_d1 = 4'b1111, g2_d1 = 4'b1111;
  logic [3:0] g1_d2 = 4'b1111, g2_d2 = 4'b1111;
  logic [3:0] g1_d3 = 4'b1111, g2_d3 = 4'b1111;

  logic d0_y1, d0_y2, d1_y1, d1_y2, d2_y1, d2_y2, d3_y1, d3_y2;

`ifdef AND_GATE_EDGE_CNT_EN
  logic [7:0] d0_c1, d0_c2, d1_c1, d1_c2, d2_c1, d2_c2, d3_c1, d3_c2;
`endif

  always #5 clk = ~clk;

  two_4_input_and_gate #(.Delay(0)) u_d0 (
    .clk(clk_hold), .rst_n(rst_n),
    .A1(g1_d0[3]), .B1(g1_d0[2]), .C1(g1_d0[1]), .D1(g1_d0[0]),
    .A2(g2_d0[3]), .B2(g2_d0[2]), .C2(g2_d0[1]), .D2(g2_d0[0]),
    .Y1(d0_y1), .Y2(d0_y2)
`ifdef AND_GATE_EDGE_CNT_EN
    , .Y1_rise_cnt(d0_c1), .Y2_rise_cnt(d0_c2)
`endif
  );

  two_4_input_and_gate #(.Delay(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .A1(g1_d1[3]), .B1(g1_d1[2]), .C1(g1_d1[1]), .D1(g1_d1[0]),
    .A2(g2_d1[3]), .B2(g2_d1[2]), .C2(g2_d1[1]), .D2(g2_d1[0]),
    .Y1(d1_y1), .Y2(d1_y2)
`ifdef AND_GATE_EDGE_CNT_EN
    , .Y1_rise_cnt(d1_c1), .Y2_rise_cnt(d1_c2)
`endif
  );

  two_4_input_and_gate #(.Delay(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .A1(g1_d2[3]), .B1(g1_d2[2]), .C1(g1_d2[1]), .D1(g1_d2[0]),
    .A2(g2_d2[3]), .B2(g2_d2[2]), .C2(g2_d2[1]), .D2(g2_d2[0]),
    .Y1(d2_y1), .Y2(d2_y2)
`ifdef AND_GATE_EDGE_CNT_EN
    , .Y1_rise_cnt(d2_c1), .Y2_rise_cnt(d2_c2)
`endif
  );

  two_4_input_and_gate #(.Delay(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .A1(g1_d3[3]), .B1(g1_d3[2]), .C1(g1_d3[1]), .D1(g1_d3[0]),
    .A2(g2_d3[3]), .B2(g2_d3[2]), .C2(g2_d3[1]), .D2(g2_d3[0]),
    .Y1(d3_y1), .Y2(d3_y2)
`ifdef AND_GATE_EDGE_CNT_EN
    , .Y1_rise_cnt(d3_c1), .Y2_rise_cnt(d3_c2)
`endif
  );

  // Expectations are kept ordered by their sample time.
  task automatic push(input int dut, input time t, input logic [7:0] e1,
                      input logic [7:0] e2, input string nm);
    sb_t e;
    int  idx;
    e.t = t; e.dut = dut; e.e1 = e1; e.e2 = e2; e.name = nm;
    idx = 0;
    while (idx < sb_q.size() && sb_q[idx].t <= t) idx++;
    sb_q.insert(idx, e);
  endtask

  // Monitor: dut 0..3 compare Y1/Y2 of that instance, dut 4 compares Delay=1 counters.
  initial begin
    sb_t        e;
    logic [7:0] a1, a2;
    forever begin
      #1;
      while (sb_q.size() != 0 && sb_q[0].t <= $time) begin
        e = sb_q.pop_front();
        a1 = 8'hEE; a2 = 8'hEE;
        case (e.dut)
          0: begin a1 = {7'b0, d0_y1}; a2 = {7'b0, d0_y2}; end
          1: begin a1 = {7'b0, d1_y1}; a2 = {7'b0, d1_y2}; end
          2: begin a1 = {7'b0, d2_y1}; a2 = {7'b0, d2_y2}; end
          3: begin a1 = {7'b0, d3_y1}; a2 = {7'b0, d3_y2}; end
`ifdef AND_GATE_EDGE_CNT_EN
          4: begin a1 = d1_c1; a2 = d1_c2; end
`endif
          default: ;
        endcase
        n_tests++;
        if (a1 !== e.e1 || a2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s @%0t: got %0d/%0d, expected %0d/%0d",
                   e.name, $time, a1, a2, e.e1, e.e2);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    logic [3:0] pat5 [8];
    logic [7:0] exp5 [8];
    pat5 = '{4'b1111, 4'b0000, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
    exp5 = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};

    // Reset holds clocked instances at 0 even with AND-true inputs and a running clock.
    for (int d = 1; d <= 3; d++) begin
      push(d, 8, 0, 0, "reset_state_early");
      push(d, 48, 0, 0, "reset_state_late");
    end

    // Test 1: Delay=0 with frozen clock, reset asserted (ignored by this instance).
    for (int i = 0; i < 16; i++) begin
      g1_d0 = 4'(i); g2_d0 = 4'b0000;
      push(0, $time + 1, (i == 15) ? 8'd1 : 8'd0, 8'd0, "t1_gate1_walk");
      #2;
    end
    for (int i = 0; i < 16; i++) begin
      g1_d0 = 4'b1111; g2_d0 = 4'(i);
      push(0, $time + 1, 8'd1, (i == 15) ? 8'd1 : 8'd0, "t1_gate2_walk");
      #2;
    end

    g1_d1 = 4'b1110; g2_d1 = 4'b0000;
    g1_d2 = 4'b0000; g2_d2 = 4'b0000;
    g1_d3 = 4'b0000; g2_d3 = 4'b0000;
    #8 rst_n = 1'b1;

    // Test 2: Delay=1 single-edge latency.
    repeat (2) @(posedge clk);
    #1 g1_d1 = 4'b1111; t0 = $time;
    push(1, t0 + 4, 0, 0, "t2_no_early_rise");
    push(1, t0 + 8, 0, 0, "t2_just_before_edge");
    push(1, t0 + 14, 1, 0, "t2_rise_next_edge");
    @(posedge clk);
    #1 g1_d1 = 4'b0111; t0 = $time;
    push(1, t0 + 4, 1, 0, "t2_still_high");
    push(1, t0 + 14, 0, 0, "t2_fall_next_edge");
    repeat (2) @(posedge clk);

    // Test 3: Delay=3 one-cycle pulse.
    @(posedge clk);
    #1 g1_d3 = 4'b1111; g2_d3 = 4'b1111; t0 = $time;
    push(3, t0 + 4, 0, 0, "t3_lat_e0");
    push(3, t0 + 14, 0, 0, "t3_lat_e1");
    push(3, t0 + 24, 0, 0, "t3_lat_e2");
    push(3, t0 + 28, 0, 0, "t3_before_e3");
    push(3, t0 + 34, 1, 1, "t3_pulse");
    push(3, t0 + 44, 0, 0, "t3_pulse_end");
    push(3, t0 + 54, 0, 0, "t3_stay_low");
    @(posedge clk);
    #1 g1_d3 = 4'b0000; g2_d3 = 4'b0000;
    repeat (6) @(posedge clk);

    // Test 4: Delay=3 asynchronous reset with full pipeline.
    #1 g1_d3 = 4'b1111; g2_d3 = 4'b1111; t0 = $time;
    push(3, t0 + 34, 1, 1, "t4_pipe_full");
    repeat (4) @(posedge clk);
    push(3, $time + 2, 1, 1, "t4_pre_reset");
    #3 rst_n = 1'b0;
    push(3, $time + 1, 0, 0, "t4_async_clear");
    #4 rst_n = 1'b1; t0 = $time;
    push(3, t0 + 8, 0, 0, "t4_after_edge1");
    push(3, t0 + 18, 0, 0, "t4_after_edge2");
    push(3, t0 + 28, 1, 1, "t4_after_edge3");
    repeat (4) @(posedge clk);

    // Test 5: Delay=2 independence.
    #1 g1_d2 = 4'b1111; g2_d2 = 4'b0000;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 g2_d2 = pat5[k];
      push(2, $time + 24, 8'd1, exp5[k], "t5_indep");
    end
    repeat (4) @(posedge clk);

`ifdef AND_GATE_EDGE_CNT_EN
    // Test 6: Delay=1 rise counter saturation and reset.
    push(4, $time + 2, 0, 0, "t6_cnt_start");
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1 g1_d1 = 4'b1111;
      @(posedge clk);
      #1 g1_d1 = 4'b0000;
      if (k == 9)   push(4, $time + 14, 10, 0, "t6_cnt_10");
      if (k == 254) push(4, $time + 14, 255, 0, "t6_cnt_255");
      if (k == 255) push(4, $time + 14, 255, 0, "t6_cnt_saturated");
    end
    repeat (3) @(posedge clk);
    push(4, $time + 2, 255, 0, "t6_cnt_final");
    push(1, $time + 2, 0, 0, "t6_y_idle");
    #4 rst_n = 1'b0;
    push(4, $time + 1, 0, 0, "t6_cnt_reset");
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
`endif

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
